// File: rtl/regfile_alu_exec.sv
// regfile_alu_exec: register file + 8-op ALU sequenced IDLE->READ->EXEC->WRITE behind a command handshake.
// Optional status flags (flag_z/n/c/v) are built when FLAGS_EN is defined.
module regfile_alu_exec #(
    parameter int DATA_W = 32,
    parameter int REG_COUNT = 32,
    localparam int ADDR_W = $clog2(REG_COUNT),
    localparam int SH_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
`ifdef FLAGS_EN
    ,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c,
    output logic              flag_v
`endif
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
    state_t state, state_nx;
    logic [DATA_W-1:0] regs [REG_COUNT];
    logic [2:0] op;
    logic [ADDR_W-1:0] rs1, rs2, rd;
    logic [DATA_W-1:0] opa, opb, alu;
    logic [SH_W-1:0] sh;
    assign sh = opb[SH_W-1:0];
    assign cmd_ready = state == IDLE;
    assign busy = state != IDLE;
    assign done = state == WRITE;
    assign dbg_rdata = regs[dbg_addr];
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = cmd_valid ? READ : IDLE;
            READ:  state_nx = EXEC;
            EXEC:  state_nx = WRITE;
            WRITE: state_nx = IDLE;
        endcase
    end
    always_comb begin
        alu = '0;
        case (op)
            3'b000: alu = opa + opb;
            3'b001: alu = opa - opb;
            3'b010: alu = opa << sh;
            3'b011: alu = opa >> sh;
            3'b100: alu = opa & opb;
            3'b101: alu = opa | opb;
            3'b110: alu = opa ^ opb;
            3'b111: alu = $signed(opa) >>> sh;
        endcase
    end
    // result is loaded on the EXEC edge, so it becomes visible exactly with done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
            op <= '0;
            rs1 <= '0;
            rs2 <= '0;
            rd <= '0;
            opa <= '0;
            opb <= '0;
            result <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && host_we) regs[host_addr] <= host_wdata;
            if (state == IDLE && cmd_valid) begin
                op <= cmd_op;
                rs1 <= cmd_rs1;
                rs2 <= cmd_rs2;
                rd <= cmd_rd;
            end
            if (state == READ) begin
                opa <= regs[rs1];
                opb <= regs[rs2];
            end
            if (state == EXEC) result <= alu;
            if (state == WRITE) regs[rd] <= result;
        end
    end
`ifdef FLAGS_EN
    logic sub;
    logic [DATA_W-1:0] bx, sum;
    logic cout;
    assign sub = op == 3'b001;
    assign bx = sub ? ~opb : opb;
    assign {cout, sum} = {1'b0, opa} + {1'b0, bx} + {{DATA_W{1'b0}}, sub};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else if (state == EXEC) begin
            flag_z <= alu == '0;
            flag_n <= alu[DATA_W-1];
            flag_c <= op[2:1] == 2'b00 && cout;
            flag_v <= op[2:1] == 2'b00 && opa[DATA_W-1] == bx[DATA_W-1] && sum[DATA_W-1] != opa[DATA_W-1];
        end
    end
`endif
endmodule

// File: tb/tb_regfile_alu_exec.sv
// tb_regfile_alu_exec: directed scoreboard bench for regfile_alu_exec.
module tb_regfile_alu_exec;
    logic clk = 1'b0, rst_n = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready, host_we = 1'b0, busy, done;
    logic [2:0] cmd_op = '0;
    logic [4:0] cmd_rs1 = '0, cmd_rs2 = '0, cmd_rd = '0, host_addr = '0, dbg_addr = '0;
    logic [31:0] host_wdata = '0, dbg_rdata, result;
    int compared = 0, mismatched = 0;
    logic [31:0] sb [$];
`ifdef FLAGS_EN
    logic flag_z, flag_n, flag_c, flag_v;
`endif

    regfile_alu_exec dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .busy(busy), .done(done), .result(result)
`ifdef FLAGS_EN
        , .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic hwrite(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        host_we = 1'b1;
        host_addr = a;
        host_wdata = d;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic cmd(input string tag, input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic [31:0] exp, input logic hw, input logic [4:0] ha,
                       input logic [31:0] hd);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_rs1 = a;
        cmd_rs2 = b;
        cmd_rd = d;
        host_we = hw;
        host_addr = ha;
        host_wdata = hd;
        sb.push_back(exp);
        @(negedge clk);
        cmd_valid = 1'b0;
        host_we = 1'b0;
        n = 1;
        chk({tag, "_busy_ready"}, {30'b0, busy, cmd_ready}, 32'h2);
        while (!done && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd3);
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        if (done) chk({tag, "_result"}, result, sb.pop_front());
        @(negedge clk);
        dbg_addr = d;
        #1 chk({tag, "_rd"}, dbg_rdata, exp);
    endtask

    initial begin
        int dones;
        // reset state and register scan
        #12;
        chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1 chk("rst_reg", dbg_rdata, 32'd0);
        end
        // ADD
        hwrite(5'd10, 32'd10);
        hwrite(5'd15, 32'd15);
        cmd("add", 3'b000, 5'd10, 5'd15, 5'd20, 32'd25, 1'b0, 5'd0, 32'd0);
        // SUB, second one with host write landing in the accept cycle
        hwrite(5'd10, 32'd20);
        cmd("sub_pos", 3'b001, 5'd10, 5'd15, 5'd21, 32'd5, 1'b0, 5'd0, 32'd0);
        hwrite(5'd10, 32'd15);
        cmd("sub_neg", 3'b001, 5'd10, 5'd15, 5'd22, 32'hFFFF_FFFB, 1'b1, 5'd15, 32'd20);
`ifdef FLAGS_EN
        chk("flags_sub_neg", {28'b0, flag_z, flag_n, flag_c, flag_v}, 32'b0100);
`endif
        // shifts and logic ops
        hwrite(5'd10, 32'd31);
        hwrite(5'd15, 32'd2);
        cmd("sll", 3'b010, 5'd10, 5'd15, 5'd1, 32'd124, 1'b0, 5'd0, 32'd0);
        cmd("srl", 3'b011, 5'd10, 5'd15, 5'd2, 32'd7, 1'b0, 5'd0, 32'd0);
        cmd("and", 3'b100, 5'd10, 5'd15, 5'd3, 32'd2, 1'b0, 5'd0, 32'd0);
        cmd("or", 3'b101, 5'd10, 5'd15, 5'd4, 32'd31, 1'b0, 5'd0, 32'd0);
        cmd("xor", 3'b110, 5'd10, 5'd15, 5'd8, 32'd29, 1'b0, 5'd0, 32'd0);
        cmd("alias", 3'b000, 5'd10, 5'd10, 5'd10, 32'd62, 1'b0, 5'd0, 32'd0);
        hwrite(5'd10, 32'h8000_0000);
        hwrite(5'd15, 32'd33);
        cmd("sra", 3'b111, 5'd10, 5'd15, 5'd9, 32'hC000_0000, 1'b0, 5'd0, 32'd0);
        cmd("sll_wrap", 3'b010, 5'd10, 5'd15, 5'd11, 32'd0, 1'b0, 5'd0, 32'd0);
        // cmd_valid held high: one command per 4 cycles; host write while busy is dropped
        hwrite(5'd6, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 3'b000;
        cmd_rs1 = 5'd5;
        cmd_rs2 = 5'd6;
        cmd_rd = 5'd5;
        sb.push_back(32'd1);
        sb.push_back(32'd2);
        sb.push_back(32'd3);
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            host_we = k == 1;
            host_addr = 5'd7;
            host_wdata = 32'hDEAD;
            if (done) begin
                dones++;
                chk("hold_result", result, sb.pop_front());
            end
        end
        cmd_valid = 1'b0;
        host_we = 1'b0;
        chk("hold_count", 32'(dones), 32'd3);
        dbg_addr = 5'd5;
        #1 chk("hold_r5", dbg_rdata, 32'd3);
        dbg_addr = 5'd7;
        #1 chk("busy_host_we", dbg_rdata, 32'd0);
        // reset during EXEC aborts the write-back
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 3'b000;
        cmd_rs1 = 5'd6;
        cmd_rs2 = 5'd6;
        cmd_rd = 5'd20;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        chk("abort_ready", {30'b0, busy, cmd_ready}, 32'd1);
        dbg_addr = 5'd20;
        #1 chk("abort_r20", dbg_rdata, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
